// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - sequential shift-and-add unsigned multiplier
//
// Computes p = a * b over several cycles with a datapath of three registers
// (multiplicand A, multiplier B, accumulator ACC) and an IDLE/CALC/DONE
// controller.
//
// Build option: SEQ_MULT_EARLY_EXIT_EN
//   defined   - CALC ends as soon as B == 0 (latency k+1, k = bit length of b)
//   undefined - CALC always runs N iterations (constant latency N+1)
//
// Ports:
//   clk   - clock, rising edge
//   clr   - synchronous active-high reset, priority over start
//   start - level request, sampled only in IDLE
//   a, b  - N-bit unsigned operands, captured on the start-accept edge
//   p     - 2N-bit registered product, holds the last completed result
//   done  - one-cycle pulse after p updates
//   busy  - high whenever the controller is not in IDLE
module seq_mult #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [2*N-1:0]   p,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [2*N-1:0]   a_q;
    logic [N-1:0]     b_q;
    logic [2*N-1:0]   acc_q;
    logic [2*N-1:0]   p_q;
    logic             done_q;

    logic             lsb_b;
    logic [2*N-1:0]   acc_d;
    logic             calc_end;

    assign lsb_b = b_q[0];
    // Max product (2^N-1)^2 fits in 2N bits, so the sum never overflows.
    assign acc_d = lsb_b ? (acc_q + a_q) : acc_q;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic zero;
    assign zero     = (b_q == '0);
    assign calc_end = zero;
`else
    // Iteration counter must reach N, hence log2(N)+1 bits.
    localparam int CW = $clog2(N) + 1;
    logic [CW-1:0] cnt_q;
    assign calc_end = (cnt_q == CW'(N));
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
`ifndef SEQ_MULT_EARLY_EXIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= {{N{1'b0}}, a};
                        b_q     <= b;
                        acc_q   <= '0;
`ifndef SEQ_MULT_EARLY_EXIT_EN
                        cnt_q   <= '0;
`endif
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (calc_end) begin
                        p_q     <= acc_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q   <= acc_d;
                        // Bits shifted out of the top of A are discarded.
                        a_q     <= a_q << 1;
                        b_q     <= b_q >> 1;
`ifndef SEQ_MULT_EARLY_EXIT_EN
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p    = p_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - directed self-checking bench for seq_mult
module tb_seq_mult;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
    logic           done;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] prev_p;

    seq_mult #(.N(N)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges from start-accept until p is written.
    function automatic int exp_lat(input logic [N-1:0] bv);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int k;
        k = 0;
        for (int i = 0; i < N; i++) if (bv[i]) k = i + 1;
        return k + 1;
`else
        return N + 1;
`endif
    endfunction

    // Called just after an edge that left the DUT in IDLE, start held high.
    // Checks accept, latency, hold of p, result, done pulse and return to IDLE.
    task automatic do_mult(input logic [N-1:0] av, input logic [N-1:0] bv,
                           input logic [2*N-1:0] exp_p, input bit switch_ops,
                           input string tag);
        int n;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        chk({tag, "_busy_accept"}, busy, 1);
        chk({tag, "_done_accept"}, done, 0);
        if (switch_ops) begin
            a = 4'd15;
            b = 4'd15;
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            chk({tag, "_p_hold"}, p, prev_p);
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat(bv));
        chk({tag, "_p"}, p, exp_p);
        chk({tag, "_done_pulse"}, done, 1);
        tick();
        chk({tag, "_done_fall"}, done, 0);
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_p_kept"}, p, exp_p);
        prev_p = exp_p;
    endtask

    initial begin
        clr = 1'b1;
        start = 1'b1;
        a = 4'd5;
        b = 4'd6;
        prev_p = '0;

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_p", p, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
        end
        clr = 1'b0;

        do_mult(4'd2, 4'd4, 8'd8, 1'b0, "m2x4");
        do_mult(4'd4, 4'd7, 8'd28, 1'b0, "m4x7");
        do_mult(4'd15, 4'd15, 8'd225, 1'b0, "m15x15");
        do_mult(4'd9, 4'd0, 8'd0, 1'b0, "m9x0");
        do_mult(4'd3, 4'd5, 8'd15, 1'b1, "m3x5_sw");
        do_mult(4'd15, 4'd15, 8'd225, 1'b0, "m_new_ops");
        do_mult(4'd4, 4'd7, 8'd28, 1'b0, "m4x7_pre");

        // Abort one cycle into CALC.
        a = 4'd4;
        b = 4'd7;
        tick();
        chk("abort_busy_accept", busy, 1);
        tick();
        chk("abort_p_before", p, 28);
        clr = 1'b1;
        tick();
        chk("abort_p", p, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        clr = 1'b0;
        prev_p = '0;

        do_mult(4'd4, 4'd7, 8'd28, 1'b0, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
